// File: rtl/convolve_reduce_loadable.sv
// convolve_reduce_loadable
//
// Pipelined 1x1 convolution that mixes the channels of one pixel.
// out[o] = narrow((sum_i in[i] * W[o][i]) >>> SHIFT)
// The weight rows can be rewritten at run time through a write port.
//
// The pipeline holds CASCADES+1 register stages:
// - Stage 0 registers the products.
// - Stages 1..CASCADES-1 register partial sums of a balanced adder tree.
// - The last stage adds the final terms, then shifts, narrows and registers the result.
//
// All stages advance together. Bubbles are not squeezed out.
//
// Ports:
//   clock_i, reset_i                     clock, asynchronous active-high reset
//   slave_valid_i/slave_ready_o/slave_data_i      input pixels, channel 0 in the low bits
//   master_valid_o/master_ready_i/master_data_o   output pixels, channel 0 in the low bits
//   weight_valid_i/weight_ready_o                  weight row write handshake
//   weight_addr_i, weight_data_i                   output channel and new row, element 0 low
//
// Build option:
//   CONVOLVE_REDUCE_LOADABLE_SATURATE_EN  clamp on narrowing instead of wrapping.

module convolve_reduce_loadable #(
    parameter int unsigned IN_CHANNELS      = 3,
    parameter int unsigned OUT_CHANNELS     = 3,
    parameter int unsigned CASCADES         = 2,
    parameter int unsigned ACTIVATION_WIDTH = 8,
    parameter int unsigned WEIGHT_WIDTH     = 8,
    parameter int unsigned SHIFT            = 0,
    parameter logic signed [0:OUT_CHANNELS-1][0:IN_CHANNELS-1][WEIGHT_WIDTH-1:0] WEIGHT = '0,
    localparam int unsigned ADDR_WIDTH = (OUT_CHANNELS > 1) ? $clog2(OUT_CHANNELS) : 1
) (
    input  logic                                   clock_i,
    input  logic                                   reset_i,
    input  logic                                   slave_valid_i,
    output logic                                   slave_ready_o,
    input  logic [IN_CHANNELS*ACTIVATION_WIDTH-1:0]  slave_data_i,
    output logic                                   master_valid_o,
    input  logic                                   master_ready_i,
    output logic [OUT_CHANNELS*ACTIVATION_WIDTH-1:0] master_data_o,
    input  logic                                   weight_valid_i,
    output logic                                   weight_ready_o,
    input  logic [ADDR_WIDTH-1:0]                  weight_addr_i,
    input  logic [IN_CHANNELS*WEIGHT_WIDTH-1:0]    weight_data_i
);

    // Smallest fan-in f with f**levels >= n.
    // This reduces n terms to one in exactly `levels` adder levels.
    function automatic int unsigned calc_fanin(input int unsigned n, input int unsigned levels);
        int unsigned f;
        int unsigned reach;
        logic        found;
        f     = n;
        found = 1'b0;
        for (int unsigned t = 1; t <= n; t++) begin
            reach = 1;
            for (int unsigned l = 0; l < levels; l++) begin
                if (reach < n) reach = reach * t;
            end
            if (!found && reach >= n) begin
                f     = t;
                found = 1'b1;
            end
        end
        return f;
    endfunction

    localparam int unsigned ACC_WIDTH = ACTIVATION_WIDTH + WEIGHT_WIDTH + $clog2(IN_CHANNELS);
    localparam int unsigned FANIN     = calc_fanin(IN_CHANNELS, CASCADES);
    localparam int unsigned EXT_WIDTH = ACC_WIDTH - ACTIVATION_WIDTH + 1;

    logic signed [WEIGHT_WIDTH-1:0] weight_q [OUT_CHANNELS][IN_CHANNELS];

    // Stage s holds up to IN_CHANNELS terms per output channel.
    // Unused tail entries stay zero because they cover no real input.
    logic signed [ACC_WIDTH-1:0] stage_q [CASCADES][OUT_CHANNELS][IN_CHANNELS];
    logic signed [ACC_WIDTH-1:0] stage_d [CASCADES][OUT_CHANNELS][IN_CHANNELS];
    logic signed [ACC_WIDTH-1:0] sum_d   [OUT_CHANNELS];
    logic signed [ACC_WIDTH-1:0] shift_d [OUT_CHANNELS];

    logic [OUT_CHANNELS*ACTIVATION_WIDTH-1:0] data_q, data_d;
    logic [CASCADES:0]                        valid_q;

    logic advance;
    logic pixel_accept;
    logic weight_accept;

    assign advance        = !valid_q[CASCADES] || master_ready_i;
    assign slave_ready_o  = advance && !weight_valid_i;
    assign pixel_accept   = slave_valid_i && slave_ready_o;
    assign weight_ready_o = weight_valid_i && !(|valid_q);
    assign weight_accept  = weight_ready_o;
    assign master_valid_o = valid_q[CASCADES];
    assign master_data_o  = data_q;

    always_comb begin
        stage_d = stage_q;
        data_d  = data_q;

        for (int o = 0; o < OUT_CHANNELS; o++) begin
            for (int i = 0; i < IN_CHANNELS; i++) begin
                stage_d[0][o][i] =
                    ACC_WIDTH'($signed(slave_data_i[i*ACTIVATION_WIDTH +: ACTIVATION_WIDTH]))
                    * ACC_WIDTH'(weight_q[o][i]);
            end
        end

        // Each tree level sums groups of FANIN neighbouring terms from the level before.
        for (int s = 1; s < CASCADES; s++) begin
            for (int o = 0; o < OUT_CHANNELS; o++) begin
                for (int j = 0; j < IN_CHANNELS; j++) begin
                    stage_d[s][o][j] = '0;
                    for (int f = 0; f < FANIN; f++) begin
                        if (j * FANIN + f < IN_CHANNELS) begin
                            stage_d[s][o][j] = stage_d[s][o][j] + stage_q[s-1][o][j*FANIN+f];
                        end
                    end
                end
            end
        end

        for (int o = 0; o < OUT_CHANNELS; o++) begin
            sum_d[o] = '0;
            for (int f = 0; f < FANIN; f++) begin
                if (f < IN_CHANNELS) sum_d[o] = sum_d[o] + stage_q[CASCADES-1][o][f];
            end
            shift_d[o] = sum_d[o] >>> SHIFT;
`ifdef CONVOLVE_REDUCE_LOADABLE_SATURATE_EN
            // Out of range when the bits above the result's sign bit are not a pure
            // sign extension.
            if (shift_d[o][ACC_WIDTH-1:ACTIVATION_WIDTH-1] !=
                {EXT_WIDTH{shift_d[o][ACC_WIDTH-1]}}) begin
                data_d[o*ACTIVATION_WIDTH +: ACTIVATION_WIDTH] = shift_d[o][ACC_WIDTH-1] ?
                    {1'b1, {(ACTIVATION_WIDTH-1){1'b0}}} : {1'b0, {(ACTIVATION_WIDTH-1){1'b1}}};
            end else begin
                data_d[o*ACTIVATION_WIDTH +: ACTIVATION_WIDTH] =
                    shift_d[o][ACTIVATION_WIDTH-1:0];
            end
`else
            data_d[o*ACTIVATION_WIDTH +: ACTIVATION_WIDTH] = shift_d[o][ACTIVATION_WIDTH-1:0];
`endif
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            valid_q <= '0;
            data_q  <= '0;
            stage_q <= '{default: '0};
        end else if (advance) begin
            valid_q <= {valid_q[CASCADES-1:0], pixel_accept};
            stage_q <= stage_d;
            // The output register only loads real results.
            // master_data_o therefore keeps the last pixel through bubbles.
            if (valid_q[CASCADES-1]) data_q <= data_d;
        end
    end

    // A write can only be accepted while the pipeline is empty.
    // In-flight pixels therefore never see a mix of two weight sets.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int o = 0; o < OUT_CHANNELS; o++) begin
                for (int i = 0; i < IN_CHANNELS; i++) begin
                    weight_q[o][i] <= WEIGHT[o][i];
                end
            end
        end else if (weight_accept && (32'(weight_addr_i) < OUT_CHANNELS)) begin
            for (int i = 0; i < IN_CHANNELS; i++) begin
                weight_q[weight_addr_i][i] <= weight_data_i[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            end
        end
    end

endmodule
